// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the iterative divider that produces the execute-stage
// {HI, LO} divide result.
//   div_state_t    : divider FSM states
//   DIV_WIDTH      : default operand width
//   DIV_CNT_W      : default iteration counter width (must hold DIV_WIDTH)
//   DIV_ZERO_QUOT  : quotient reported for a zero divisor (all ones)
//   div_hi/div_lo  : field accessors for the packed {HI, LO} result
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVZERO = 2'd1,
        CALC    = 2'd2,
        DONE    = 2'd3
    } div_state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

    // HI (remainder) occupies [2*WIDTH-1:WIDTH], LO (quotient) [WIDTH-1:0].
    function automatic logic [DIV_WIDTH-1:0] div_hi(input logic [2*DIV_WIDTH-1:0] r);
        return r[2*DIV_WIDTH-1:DIV_WIDTH];
    endfunction

    function automatic logic [DIV_WIDTH-1:0] div_lo(input logic [2*DIV_WIDTH-1:0] r);
        return r[DIV_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// -----------------------------------------------------------------------------
// div_sign_fix
// Combinational conditional two's-complement negate. Used both to take the
// magnitude of the operands when a divide starts and to restore the signs of
// the quotient and remainder when the result is registered.
//   val : input value
//   neg : 1 = output the two's-complement negation of val
//   res : neg ? -val : val
// -----------------------------------------------------------------------------
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);

    assign res = neg ? (~val + 1'b1) : val;

endmodule

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter
// Iterative radix-2 restoring divider for MIPS DIV/DIVU. One quotient bit is
// produced per cycle on operand magnitudes; signs are reapplied on the way into
// the result register. A zero divisor short-cuts to a fixed result.
//   clk          : clock, all state updates on the rising edge
//   rst          : synchronous active-low reset
//   flush        : pipeline flush, cancels any operation in flight
//   annul_i      : explicit cancel, same effect as flush
//   opdata1_i    : dividend
//   opdata2_i    : divisor
//   start_i      : request, held high by the consumer until ready_o
//   signed_div_i : 1 = signed (DIV), 0 = unsigned (DIVU)
//   ready_o      : result valid, one cycle per completed operation
//   result_o     : {remainder, quotient} = {HI, LO}
// -----------------------------------------------------------------------------
module div_iter
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               annul_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               signed_div_i,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o
);

    // Sign-extending the all-ones constant keeps it all ones at any WIDTH.
    localparam logic [WIDTH-1:0] ZERO_QUOT = WIDTH'(signed'(DIV_ZERO_QUOT));

    div_state_t state;
    div_state_t state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   rem;        // partial remainder
    logic [WIDTH-1:0]   dvd;        // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0]   dvs;        // divisor magnitude
    logic               sign_q;
    logic               sign_r;
    logic [2*WIDTH-1:0] result;

    logic               cancel;
    logic               last_iter;
    logic               div_zero;
    logic               accept;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    logic [WIDTH+1:0]   trial;
    logic               qbit;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quot_nxt;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   quot_fix;

    assign cancel    = flush | annul_i;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign div_zero  = (opdata2_i == '0);
    assign accept    = (state == IDLE) && (state_nxt != IDLE);

    assign a_neg = signed_div_i & opdata1_i[WIDTH-1];
    assign b_neg = signed_div_i & opdata2_i[WIDTH-1];

    div_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.val(opdata1_i), .neg(a_neg), .res(abs_a));
    div_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.val(opdata2_i), .neg(b_neg), .res(abs_b));

    // Trial subtract of the divisor from {rem, next dividend bit}. The extra
    // top bit acts as the borrow: clear means the subtraction fits.
    assign trial    = {1'b0, rem, dvd[WIDTH-1]} - {2'b00, dvs};
    assign qbit     = ~trial[WIDTH+1];
    assign rem_nxt  = qbit ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], dvd[WIDTH-1]};
    assign quot_nxt = {dvd[WIDTH-2:0], qbit};

    // Signs are reapplied to the final iteration's values so the result can be
    // registered on the same edge that enters DONE.
    div_sign_fix #(.WIDTH(WIDTH)) u_fix_rem  (.val(rem_nxt),  .neg(sign_r), .res(rem_fix));
    div_sign_fix #(.WIDTH(WIDTH)) u_fix_quot (.val(quot_nxt), .neg(sign_q), .res(quot_fix));

    // ---------------------------------------------------------------- FSM ---
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = div_zero ? DIVZERO : CALC;
            DIVZERO: state_nxt = DONE;
            CALC:    if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;   // start_i is ignored here
            default: state_nxt = IDLE;
        endcase
        if (cancel) begin
            state_nxt = IDLE;
        end
    end

    // ------------------------------------------------------ iteration count ---
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state == CALC && state_nxt == CALC) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    // ------------------------------------------------------------ datapath ---
    always_ff @(posedge clk) begin
        if (accept) begin
            sign_q <= a_neg ^ b_neg;
            sign_r <= a_neg;
            // For a zero divisor the raw dividend is kept: it becomes HI.
            dvd    <= div_zero ? opdata1_i : abs_a;
            dvs    <= abs_b;
            rem    <= '0;
        end else if (state == CALC) begin
            rem    <= rem_nxt;
            dvd    <= quot_nxt;
        end
    end

    // -------------------------------------------------------------- result ---
    always_ff @(posedge clk) begin
        if (!rst) begin
            result <= '0;
        end else if (state_nxt == DONE) begin
            if (state == DIVZERO) begin
                result <= {dvd, ZERO_QUOT};
            end else begin
                result <= {rem_fix, quot_fix};
            end
        end
    end

    assign ready_o  = (state == DONE);
    assign result_o = result;

endmodule

// File: tb/tb_div_iter.sv
// -----------------------------------------------------------------------------
// tb_div_iter
// Directed-vector bench for div_iter with hand-computed expected results.
// -----------------------------------------------------------------------------
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        annul_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        signed_div_i;
    logic        ready_o;
    logic [63:0] result_o;

    int n_chk  = 0;
    int n_pass = 0;
    logic [63:0] last_res;

    always #5 clk = ~clk;

    div_iter #(.WIDTH(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .annul_i      (annul_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .signed_div_i (signed_div_i),
        .ready_o      (ready_o),
        .result_o     (result_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Launch one divide with start held, count edges after the start edge
    // until ready_o, then check latency, result and the single-cycle pulse.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input int exp_edges, input logic [63:0] exp_res);
        int k;
        k = 0;
        @(negedge clk);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sgn;
        start_i      = 1'b1;
        @(posedge clk);
        #1;
        while (!ready_o && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        start_i = 1'b0;
        chk({tag, "_lat"}, 64'(k), 64'(exp_edges));
        chk({tag, "_res"}, result_o, exp_res);
        last_res = exp_res;
        @(posedge clk);
        #1;
        chk({tag, "_rdy_low"}, {63'd0, ready_o}, 64'd0);
    endtask

    initial begin
        int k;
        int highs;
        logic [63:0] r1;

        rst          = 1'b0;
        flush        = 1'b0;
        annul_i      = 1'b0;
        start_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        last_res     = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", {63'd0, ready_o}, 64'd0);
        chk("reset_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        do_div("u100_7",   32'd100,        32'd7,          1'b0, 32, {32'd2, 32'd14});
        do_div("s_m7_2",   32'hFFFF_FFF9,  32'd2,          1'b1, 32, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_div("u_m7_2",   32'hFFFF_FFF9,  32'd2,          1'b0, 32, {32'd1, 32'h7FFF_FFFC});
        do_div("s_divz",   32'h0000_1234,  32'd0,          1'b1, 1,  {32'h0000_1234, 32'hFFFF_FFFF});
        do_div("s_ovf",    32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32, {32'd0, 32'h8000_0000});
        do_div("s_7_m2",   32'd7,          32'hFFFF_FFFE,  1'b1, 32, {32'd1, 32'hFFFF_FFFD});
        do_div("s_m8_m3",  32'hFFFF_FFF8,  32'hFFFF_FFFD,  1'b1, 32, {32'hFFFF_FFFE, 32'd2});
        do_div("u_max_1",  32'hFFFF_FFFF,  32'd1,          1'b0, 32, {32'd0, 32'hFFFF_FFFF});
        do_div("u_divz",   32'hFFFF_FFFF,  32'd0,          1'b0, 1,  {32'hFFFF_FFFF, 32'hFFFF_FFFF});

        // Flush part way through CALC, then a fresh divide on the next cycle.
        @(negedge clk);
        opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush   = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("flush_ready", {63'd0, ready_o}, 64'd0);
        chk("flush_result", result_o, last_res);
        flush = 1'b0;
        do_div("after_flush", 32'd9, 32'd3, 1'b0, 32, {32'd0, 32'd3});

        // Annul while in DIVZERO: no completion, result unchanged.
        @(negedge clk);
        opdata1_i = 32'h55; opdata2_i = 32'd0; signed_div_i = 1'b0; start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        highs = 0;
        for (int i = 0; i < 4; i++) begin
            if (ready_o) highs++;
            @(posedge clk);
            #1;
        end
        chk("annul_no_ready", 64'(highs), 64'd0);
        chk("annul_result", result_o, last_res);

        // Reset pulse mid-CALC.
        @(negedge clk);
        opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_ready", {63'd0, ready_o}, 64'd0);
        chk("midrst_result", result_o, 64'd0);
        last_res = '0;
        @(negedge clk);
        rst   = 1'b1;
        highs = 0;
        for (int i = 0; i < 36; i++) begin
            @(posedge clk);
            #1;
            if (ready_o) highs++;
        end
        chk("midrst_no_ready", 64'(highs), 64'd0);

        // Back-to-back with start held continuously.
        @(negedge clk);
        opdata1_i = 32'd10; opdata2_i = 32'd3; signed_div_i = 1'b0; start_i = 1'b1;
        @(posedge clk);
        #1;
        k = 0;
        while (!ready_o && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("b2b_first_lat", 64'(k), 64'd32);
        r1 = result_o;
        chk("b2b_first_res", r1, {32'd1, 32'd3});
        opdata1_i = 32'd20;
        opdata2_i = 32'd6;
        k = 0;
        @(posedge clk);
        #1;
        k++;
        chk("b2b_gap_ready_low", {63'd0, ready_o}, 64'd0);
        while (!ready_o && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        start_i = 1'b0;
        chk("b2b_gap", 64'(k), 64'd34);
        chk("b2b_second_res", result_o, {32'd2, 32'd3});
        @(posedge clk);
        #1;
        chk("b2b_rdy_low", {63'd0, ready_o}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_result", result_o, {32'd2, 32'd3});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Iterative radix-2 restoring divider that is the sole producer of the execute-stage `{HI, LO}` divide result.
- Sits directly under the ALU. The ALU holds `start_i` high and stalls the pipe until `ready_o`, then writes `result_o` into HI/LO.
- Handles MIPS DIV/DIVU, signed and unsigned, with a deterministic divide-by-zero result and pipeline flush cancellation.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low.
- flush  input  1  pipeline flush; cancels any operation.
- annul_i  input  1  explicit cancel; same effect as flush.
- opdata1_i  input  WIDTH  dividend.
- opdata2_i  input  WIDTH  divisor.
- start_i  input  1  request; held high by the consumer until ready_o.
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU).
- ready_o  output  1  result valid; exactly one cycle per operation.
- result_o  output  2*WIDTH  {remainder, quotient} = {HI, LO}.

Behaviour:
- Reset (rst==0 at an edge):
  - state=IDLE, counter=0, ready_o=0, result_o=0.
  - Reset has priority over flush, annul_i and start_i.
- States: IDLE, DIVZERO, CALC, DONE. ready_o = (state==DONE), driven from a register, no combinational path from inputs.
- IDLE, start_i=1, no flush/annul:
  - Latch sign_q = signed & (a[31]^b[31]) and sign_r = signed & a[31].
  - Latch |a| and |b| (two's-complement abs when signed; raw when unsigned).
  - Divisor==0 -> DIVZERO; else -> CALC with counter=0 and partial remainder=0.
- DIVZERO: next cycle -> DONE with result_o = {opdata1 latched, {WIDTH{1'b1}}}.
- CALC, one quotient bit per cycle:
  - WIDTH+1-bit trial subtract of divisor from {rem, next dividend bit}.
  - Non-negative -> keep difference, shift in 1; else restore, shift in 0.
  - After WIDTH iterations -> DONE.
- Latency: start sampled at edge T; ready_o high in cycle T+WIDTH+1 (33 for WIDTH=32). Divide-by-zero: ready_o in cycle T+2.
- DONE:
  - result_o = {sign_r ? -rem : rem, sign_q ? -quot : quot}, registered on entry to DONE.
  - Next cycle -> IDLE unconditionally; start_i is ignored in DONE.
  - A back-to-back divide starts at the following IDLE cycle.
- result_o holds its value after DONE until the next DONE or reset.
- Operand changes and start_i deassertion during CALC/DIVZERO are ignored; operands are latched at start.
- flush or annul_i in any state: next state IDLE, counter cleared, no DONE produced, result_o unchanged.
  - Flush in the DONE cycle: ready_o still high that cycle; the consumer gates the HI/LO write.
- Signed overflow: -2^31 / -1 gives quotient 0x8000_0000 (wrap), remainder 0; no exception.
- Remainder sign always follows the dividend; |rem| < |divisor|.

Decomposition:
- Package div_pkg:
  - state enum div_state_t {IDLE, DIVZERO, CALC, DONE}.
  - DIV_ZERO_QUOT constant (all ones).
  - Result field positions: HI = [2*WIDTH-1:WIDTH], LO = [WIDTH-1:0].
- One natural sub-module: div_sign_fix, a combinational abs/negate helper used at latch and at DONE.
- The FSM and datapath stay in div_iter.

Test Plan:
- Unsigned 100/7, start held: ready_o one cycle at T+33; result_o = {32'd2, 32'd14}; ready_o low at T+34.
- Signed -7/2 (0xFFFFFFF9 / 2): result_o = {0xFFFFFFFF, 0xFFFFFFFD}, i.e. rem -1, quot -3. Same operands as unsigned: quot 0x7FFFFFFC, rem 1.
- Divide by zero 0x1234/0, signed: ready_o at T+2; result_o = {0x00001234, 0xFFFFFFFF}.
- Signed 0x80000000 / 0xFFFFFFFF: result_o = {0, 0x80000000}, latency 33.
- Flush at CALC iteration 10, then new start 9/3 next cycle: no ready_o for the first op; second op yields {0, 3} at its own T+33.
- rst low mid-CALC for one cycle: ready_o=0, result_o=0 after the edge. Back-to-back starts 10/3 then 20/6: two single-cycle ready pulses, {1,3} and {2,3}, separated by one IDLE cycle plus 33.
